bidir_port_ctrl: RTL

// - Parametrised bidirectional pad/bus port controller. Owns an inout bus of WIDTH bits shared

---
 rtl/bidir_pkg.sv | 18 +
 rtl/bidir_turn_cnt.sv | 34 +++
 rtl/bidir_port_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bidir_pkg.sv
// bidir_pkg: shared types and widths for the bidirectional port controller.
//   bidir_state_e : direction FSM states
//   TURN_W        : width of the turnaround down-counter (covers TURN_CYC up to 15)
//   CONT_W        : width of the read-back mismatch counter (covers CONT_CYC up to 7)
package bidir_pkg;

    typedef enum logic [2:0] {
        ST_RX,
        ST_TURN_TX,
        ST_TX,
        ST_TURN_RX,
        ST_HOLD
    } bidir_state_e;

    localparam int unsigned TURN_W = 4;
    localparam int unsigned CONT_W = 3;

endpackage

// File: rtl/bidir_turn_cnt.sv
// bidir_turn_cnt: loadable down-counter with zero flag, used to time the hi-Z gap in both
// turnaround states.
//   clk      in   clock
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   value to load
//   dec      in   decrement by one, stops at zero
//   zero     out  count is zero
module bidir_turn_cnt
    import bidir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TURN_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [TURN_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && !zero) begin
            count_q <= count_q - TURN_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/bidir_port_ctrl.sv
// bidir_port_ctrl: direction controller for an inout bus shared with one external driver.
// Direction changes always pass through TURN_CYC hi-Z cycles. While transmitting, the bus is
// read back; CONT_CYC consecutive mismatches latch cont_err and park the port released in HOLD
// until reset.
//   clk       in     clock
//   rst       in     synchronous active-high reset
//   io        inout  shared bus, driven only while oe=1
//   dir_req   in     1=transmit, 0=receive
//   dir_ack   out    settled in the requested direction
//   tx_valid  in     TX word offered
//   tx_data   in     TX word
//   tx_ready  out    TX word accepted when tx_valid & tx_ready
//   rx_valid  out    one-cycle pulse per received word
//   rx_data   out    received word
//   oe        out    registered bus drive enable
//   cont_err  out    sticky contention flag
module bidir_port_ctrl
    import bidir_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned CONT_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] io,
    input  logic             dir_req,
    output logic             dir_ack,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             oe,
    output logic             cont_err
);

    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);
    localparam logic [CONT_W-1:0] CONT_LAST = CONT_W'(CONT_CYC - 1);

    bidir_state_e     state_q, state_d;
    logic [WIDTH-1:0] dout_q, rx_data_q;
    logic             oe_q, oe_prev_q, rx_valid_q, cont_err_q;
    logic [CONT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             chk_en, mismatch, cont_hit, rx_take;

    assign io = oe_q ? dout_q : {WIDTH{1'bz}};

    bidir_turn_cnt u_turn_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (TURN_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Read-back starts one cycle after oe rises so the pad has settled.
    assign chk_en = (state_q == ST_TX) && oe_prev_q;

    // Written so that an unknown or floating compare counts as a mismatch.
    always_comb begin
        mismatch = 1'b1;
        if (io == dout_q) begin
            mismatch = 1'b0;
        end
    end

    assign cont_hit = chk_en && mismatch && (mis_cnt_q == CONT_LAST);

    always_comb begin
        mis_cnt_d = '0;
        if (chk_en && mismatch) begin
            mis_cnt_d = mis_cnt_q + CONT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_RX: begin
                if (dir_req && !cont_err_q) begin
                    state_d  = ST_TURN_TX;
                    cnt_load = 1'b1;
                end
            end
            ST_TURN_TX: begin
                if (!dir_req) begin
                    state_d  = ST_TURN_RX;
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_TX;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_TX: begin
                // Contention wins over a simultaneous direction drop.
                if (cont_hit) begin
                    state_d = ST_HOLD;
                end else if (!dir_req) begin
                    state_d  = ST_TURN_RX;
                    cnt_load = 1'b1;
                end
            end
            ST_TURN_RX: begin
                if (cnt_zero) begin
                    state_d = ST_RX;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_RX;
            end
        endcase
    end

    // Only sample while staying in RX so nothing is captured on the way into turnaround.
    assign rx_take = (state_q == ST_RX) && (state_d == ST_RX);

    assign tx_ready = (state_q == ST_TX) && dir_req;

    always_comb begin
        dir_ack = 1'b0;
        if (state_q == ST_RX) begin
            dir_ack = !dir_req;
        end else if (state_q == ST_TX) begin
            dir_ack = dir_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RX;
            oe_q       <= 1'b0;
            oe_prev_q  <= 1'b0;
            dout_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cont_err_q <= 1'b0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            oe_q       <= (state_d == ST_TX);
            oe_prev_q  <= oe_q;
            mis_cnt_q  <= mis_cnt_d;
            rx_valid_q <= rx_take;
            if (tx_valid && tx_ready) begin
                dout_q <= tx_data;
            end
            if (rx_take) begin
                rx_data_q <= io;
            end
            if (cont_hit) begin
                cont_err_q <= 1'b1;
            end
        end
    end

    assign oe       = oe_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign cont_err = cont_err_q;

endmodule
